// File: rtl/hack_alu_pkg.sv
// Shared types and constants for the Hack ALU and its multi-requester front end.
// Control words are laid out {zx,nx,zy,ny,f,no}, MSB first.
package hack_alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    localparam logic [5:0] ALU_ZERO      = 6'b101010;
    localparam logic [5:0] ALU_ONE       = 6'b111111;
    localparam logic [5:0] ALU_NEG1      = 6'b111010;
    localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;

    // Round-robin candidate index; base and offset are each below n, so one subtract wraps it.
    function automatic int rr_index(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Purely combinational Hack ALU: optional zero/negate on each operand,
// add or AND, optional negate of the result, plus zero/negative flags.
module hack_alu
    import hack_alu_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  alu_ctrl_t   ctrl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_zeroed;
    logic [15:0] x_final;
    logic [15:0] y_zeroed;
    logic [15:0] y_final;
    logic [15:0] f_result;

    always_comb begin
        x_zeroed = ctrl.zx ? 16'h0000 : x;
        x_final  = ctrl.nx ? ~x_zeroed : x_zeroed;
        y_zeroed = ctrl.zy ? 16'h0000 : y;
        y_final  = ctrl.ny ? ~y_zeroed : y_zeroed;
        // The carry out of the add is deliberately dropped.
        f_result = ctrl.f ? (x_final + y_final) : (x_final & y_final);
        out      = ctrl.no ? ~f_result : f_result;
        zr       = (out == 16'h0000);
        ng       = out[15];
    end

endmodule

// File: rtl/hack_alu_arbiter.sv
// Round-robin front end sharing one hack_alu between N_REQ requesters,
// with a single registered response slot tagged by the winning requester.
module hack_alu_arbiter
    import hack_alu_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*16-1:0]      req_x,
    input  logic [N_REQ*16-1:0]      req_y,
    input  logic [N_REQ*6-1:0]       req_ctrl,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [15:0]              rsp_out,
    output logic                     rsp_zr,
    output logic                     rsp_ng
);

    localparam int ID_W = $clog2(N_REQ);

    rsp_state_t      state;
    logic [ID_W-1:0] last_grant;

    logic            can_accept;
    logic            found;
    logic            accept;
    int              idx;
    logic [ID_W-1:0] winner;
    logic [15:0]     sel_x;
    logic [15:0]     sel_y;
    alu_ctrl_t       sel_ctrl;

    logic [15:0]     alu_out;
    logic            alu_zr;
    logic            alu_ng;

    assign can_accept = (state == EMPTY) || rsp_ready;

    // Search from the requester after the last winner; the winner's operands feed the ALU directly.
    always_comb begin
        found    = 1'b0;
        idx      = 0;
        winner   = '0;
        sel_x    = '0;
        sel_y    = '0;
        sel_ctrl = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_valid[rr_index(int'(last_grant), k, N_REQ)]) begin
                found = 1'b1;
                idx   = rr_index(int'(last_grant), k, N_REQ);
            end
        end
        winner   = ID_W'(idx);
        sel_x    = req_x[idx*16 +: 16];
        sel_y    = req_y[idx*16 +: 16];
        sel_ctrl = alu_ctrl_t'(req_ctrl[idx*6 +: 6]);
    end

    always_comb begin
        req_ready = '0;
        if (!rst && can_accept && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept = |req_ready;

    hack_alu u_alu (
        .x    (sel_x),
        .y    (sel_y),
        .ctrl (sel_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Accept and drain can share an edge, so a new result simply overwrites the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            last_grant <= ID_W'(N_REQ - 1);
            rsp_id     <= '0;
            rsp_out    <= '0;
            rsp_zr     <= 1'b0;
            rsp_ng     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (rsp_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                last_grant <= winner;
                rsp_id     <= winner;
                rsp_out    <= alu_out;
                rsp_zr     <= alu_zr;
                rsp_ng     <= alu_ng;
            end
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Directed bench for hack_alu_arbiter: a two-requester instance for the handshake
// scenarios and a four-requester instance for round-robin fairness.
module tb_hack_alu_arbiter;
    import hack_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0]  v2 = '0;
    logic [1:0]  rdy2;
    logic [31:0] x2 = '0;
    logic [31:0] y2 = '0;
    logic [11:0] c2 = '0;
    logic        rr2 = 1'b0;
    logic        rv2;
    logic [0:0]  id2;
    logic [15:0] out2;
    logic        zr2;
    logic        ng2;

    logic [3:0]  v4 = '0;
    logic [3:0]  rdy4;
    logic [63:0] x4 = '0;
    logic [63:0] y4 = '0;
    logic [23:0] c4 = '0;
    logic        rr4 = 1'b0;
    logic        rv4;
    logic [1:0]  id4;
    logic [15:0] out4;
    logic        zr4;
    logic        ng4;

    hack_alu_arbiter #(.N_REQ(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v2),
        .req_ready (rdy2),
        .req_x     (x2),
        .req_y     (y2),
        .req_ctrl  (c2),
        .rsp_valid (rv2),
        .rsp_ready (rr2),
        .rsp_id    (id2),
        .rsp_out   (out2),
        .rsp_zr    (zr2),
        .rsp_ng    (ng2)
    );

    hack_alu_arbiter #(.N_REQ(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v4),
        .req_ready (rdy4),
        .req_x     (x4),
        .req_y     (y4),
        .req_ctrl  (c4),
        .rsp_valid (rv4),
        .rsp_ready (rr4),
        .rsp_id    (id4),
        .rsp_out   (out4),
        .rsp_zr    (zr4),
        .rsp_ng    (ng4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int i, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        x2[i*16 +: 16] = x;
        y2[i*16 +: 16] = y;
        c2[i*6 +: 6]   = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v2  = 2'b11;
        v4  = 4'hF;
        tick();
        tick();
        compared++;
        if (rdy2 !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_ready2: got %b expected 00", rdy2);
        end
        compared++;
        if (rdy4 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_ready4: got %b expected 0000", rdy4);
        end
        compared++;
        if ({rv2, id2, out2, zr2, ng2} !== 20'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rsp2: got %h expected 00000", {rv2, id2, out2, zr2, ng2});
        end
        compared++;
        if ({rv4, id4, out4, zr4, ng4} !== 21'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rsp4: got %h expected 000000", {rv4, id4, out4, zr4, ng4});
        end
        rst = 1'b0;
        v2  = 2'b00;
        v4  = 4'h0;
        tick();
    endtask

    task automatic test_single_op();
        set2(0, 16'd5, 16'd3, ALU_X_PLUS_Y);
        v2  = 2'b01;
        rr2 = 1'b1;
        #1;
        compared++;
        if (rdy2 !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL single_ready: got %b expected 01", rdy2);
        end
        tick();
        v2 = 2'b00;
        compared++;
        if ({rv2, id2, out2, zr2, ng2} !== {1'b1, 1'b0, 16'h0008, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL single_rsp: got %h expected %h", {rv2, id2, out2, zr2, ng2},
                     {1'b1, 1'b0, 16'h0008, 1'b0, 1'b0});
        end
        tick();
        compared++;
        if ({rv2, out2} !== {1'b0, 16'h0008}) begin
            mismatched++;
            $display("[TB] FAIL single_drain: got %h expected %h", {rv2, out2}, {1'b0, 16'h0008});
        end
    endtask

    task automatic test_contention();
        logic [0:0]  e_id;
        logic [15:0] e_out;
        logic        e_zr;
        logic        e_ng;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set2(0, 16'd3, 16'd5, ALU_X_MINUS_Y);
        set2(1, 16'h00F0, 16'h0F00, ALU_X_AND_Y);
        v2  = 2'b11;
        rr2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e_id  = 1'(i % 2);
            e_out = e_id[0] ? 16'h0000 : 16'hFFFE;
            e_zr  = e_id[0];
            e_ng  = ~e_id[0];
            #1;
            compared++;
            if (rdy2 !== (e_id[0] ? 2'b10 : 2'b01)) begin
                mismatched++;
                $display("[TB] FAIL contention_ready[%0d]: got %b expected %b", i, rdy2,
                         (e_id[0] ? 2'b10 : 2'b01));
            end
            tick();
            compared++;
            if ({rv2, id2, out2, zr2, ng2} !== {1'b1, e_id, e_out, e_zr, e_ng}) begin
                mismatched++;
                $display("[TB] FAIL contention_rsp[%0d]: got %h expected %h", i,
                         {rv2, id2, out2, zr2, ng2}, {1'b1, e_id, e_out, e_zr, e_ng});
            end
        end
    endtask

    task automatic test_backpressure();
        set2(1, 16'h1234, 16'h0011, ALU_X_PLUS_Y);
        v2  = 2'b10;
        rr2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (rdy2 !== 2'b00) begin
                mismatched++;
                $display("[TB] FAIL stall_ready[%0d]: got %b expected 00", i, rdy2);
            end
            tick();
            compared++;
            if ({rv2, id2, out2, zr2, ng2} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i,
                         {rv2, id2, out2, zr2, ng2}, {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
            end
        end
        rr2 = 1'b1;
        #1;
        compared++;
        if (rdy2 !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL release_ready: got %b expected 10", rdy2);
        end
        tick();
        v2 = 2'b00;
        compared++;
        if ({rv2, id2, out2, zr2, ng2} !== {1'b1, 1'b1, 16'h1245, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL release_rsp: got %h expected %h", {rv2, id2, out2, zr2, ng2},
                     {1'b1, 1'b1, 16'h1245, 1'b0, 1'b0});
        end
        tick();
        compared++;
        if (rv2 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_drain: got %b expected 0", rv2);
        end
    endtask

    task automatic test_wrap();
        logic [5:0]  ctrl_tab [4];
        logic [17:0] exp_tab  [4];
        ctrl_tab = '{ALU_X_PLUS_Y, ALU_NEG1, ALU_ONE, ALU_ZERO};
        exp_tab  = '{{16'h8000, 1'b0, 1'b1}, {16'hFFFF, 1'b0, 1'b1},
                     {16'h0001, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}};
        rr2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set2(0, 16'h7FFF, 16'h0001, ctrl_tab[i]);
            v2 = 2'b01;
            #1;
            compared++;
            if (rdy2 !== 2'b01) begin
                mismatched++;
                $display("[TB] FAIL wrap_ready[%0d]: got %b expected 01", i, rdy2);
            end
            tick();
            compared++;
            if ({rv2, id2, out2, zr2, ng2} !== {1'b1, 1'b0, exp_tab[i]}) begin
                mismatched++;
                $display("[TB] FAIL wrap_rsp[%0d]: got %h expected %h", i,
                         {rv2, id2, out2, zr2, ng2}, {1'b1, 1'b0, exp_tab[i]});
            end
        end
        v2 = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_op();
        set2(0, 16'h4000, 16'h4000, ALU_X_PLUS_Y);
        set2(1, 16'h0002, 16'h0003, ALU_X_PLUS_Y);
        v2  = 2'b01;
        rr2 = 1'b1;
        tick();
        compared++;
        if ({rv2, out2} !== {1'b1, 16'h8000}) begin
            mismatched++;
            $display("[TB] FAIL midreset_fill: got %h expected %h", {rv2, out2}, {1'b1, 16'h8000});
        end
        rr2 = 1'b0;
        v2  = 2'b11;
        rst = 1'b1;
        #1;
        compared++;
        if (rdy2 !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL midreset_ready: got %b expected 00", rdy2);
        end
        tick();
        rst = 1'b0;
        compared++;
        if ({rv2, id2, out2, zr2, ng2} !== 20'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_rsp: got %h expected 00000", {rv2, id2, out2, zr2, ng2});
        end
        rr2 = 1'b1;
        #1;
        compared++;
        if (rdy2 !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL midreset_first_grant: got %b expected 01", rdy2);
        end
        tick();
        v2 = 2'b00;
        compared++;
        if ({rv2, id2, out2, zr2, ng2} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL midreset_after: got %h expected %h", {rv2, id2, out2, zr2, ng2},
                     {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
        end
        tick();
    endtask

    task automatic test_fairness();
        int seq_all  [8];
        int seq_drop [6];
        seq_all  = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_drop = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < 4; i++) begin
            x4[i*16 +: 16] = 16'(i);
            y4[i*16 +: 16] = 16'h0010;
            c4[i*6 +: 6]   = ALU_X_PLUS_Y;
        end
        v4  = 4'hF;
        rr4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            compared++;
            if (rdy4 !== 4'(1 << seq_all[i])) begin
                mismatched++;
                $display("[TB] FAIL fair_ready[%0d]: got %b expected %b", i, rdy4, 4'(1 << seq_all[i]));
            end
            tick();
            compared++;
            if ({rv4, id4, out4} !== {1'b1, 2'(seq_all[i]), 16'(16 + seq_all[i])}) begin
                mismatched++;
                $display("[TB] FAIL fair_rsp[%0d]: got %h expected %h", i, {rv4, id4, out4},
                         {1'b1, 2'(seq_all[i]), 16'(16 + seq_all[i])});
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v4  = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++;
            if ({rv4, id4, out4} !== {1'b1, 2'(seq_drop[i]), 16'(16 + seq_drop[i])}) begin
                mismatched++;
                $display("[TB] FAIL fair_drop_rsp[%0d]: got %h expected %h", i, {rv4, id4, out4},
                         {1'b1, 2'(seq_drop[i]), 16'(16 + seq_drop[i])});
            end
        end
        v4 = 4'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_mid_op();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
